// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - 7-segment bus receiver: glitch filter, hex decode, digit-change interval timer
module seg7_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [6:0]       seg_in,
   output logic [3:0]       digit,
   output logic             digit_valid,
   output logic             blank,
   output logic             seg_err,
   output logic [CNT_W-1:0] interval,
   output logic             interval_ovf
);

   localparam int                STAB_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  ICNT_MAX = '1;
   localparam logic [CNT_W-1:0]  ICNT_ONE = CNT_W'(1);

   typedef enum logic {WAIT_FIRST, RUN} state_t;

   logic [6:0]        meta, sync, cand, accepted, pend_pat;
   logic [STAB_W-1:0] stab;
   logic              accept, pend;
   logic              hit;
   logic [3:0]        dec_val;
   logic              dv_r, err_r;
   state_t            state, state_nxt;
   logic [CNT_W-1:0]  icnt, icnt_nxt, interval_nxt;
   logic              ovf_int, ovf_nxt, interval_ovf_nxt;
   logic              take_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= seg_in;
         sync <= meta;
      end
   end

   assign accept = (sync == cand) && (stab == STAB_MAX) && (cand != accepted) && ena;

   // Accepted pattern is staged one cycle in pend/pend_pat before it reaches the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand     <= '0;
         stab     <= '0;
         accepted <= '0;
         pend     <= 1'b0;
         pend_pat <= '0;
      end else if (ena) begin
         if (sync != cand) begin
            cand <= sync;
            stab <= '0;
         end else if (stab < STAB_MAX) begin
            stab <= stab + 1'b1;
         end
         pend <= accept;
         if (accept) begin
            accepted <= cand;
            pend_pat <= cand;
         end
      end
   end

   always_comb begin
      hit     = 1'b1;
      dec_val = 4'h0;
      case (pend_pat)
         7'h3F: dec_val = 4'h0;
         7'h06: dec_val = 4'h1;
         7'h5B: dec_val = 4'h2;
         7'h4F: dec_val = 4'h3;
         7'h66: dec_val = 4'h4;
         7'h6D: dec_val = 4'h5;
         7'h7D: dec_val = 4'h6;
         7'h07: dec_val = 4'h7;
         7'h7F: dec_val = 4'h8;
         7'h6F: dec_val = 4'h9;
         7'h77: dec_val = 4'hA;
         7'h7C: dec_val = 4'hB;
         7'h39: dec_val = 4'hC;
         7'h5E: dec_val = 4'hD;
         7'h79: dec_val = 4'hE;
         7'h71: dec_val = 4'hF;
         default: hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= '0;
         blank <= 1'b0;
         dv_r  <= 1'b0;
         err_r <= 1'b0;
      end else begin
         dv_r  <= 1'b0;
         err_r <= 1'b0;
         if (ena && pend) begin
            if (hit) begin
               digit <= dec_val;
               dv_r  <= 1'b1;
               blank <= 1'b0;
            end else if (pend_pat == 7'h00) begin
               blank <= 1'b1;
            end else begin
               err_r <= 1'b1;
            end
         end
      end
   end

   assign digit_valid = dv_r & ena;
   assign seg_err     = err_r & ena;
   assign take_hit    = ena && pend && hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= WAIT_FIRST;
         icnt         <= '0;
         ovf_int      <= 1'b0;
         interval     <= '0;
         interval_ovf <= 1'b0;
      end else begin
         state        <= state_nxt;
         icnt         <= icnt_nxt;
         ovf_int      <= ovf_nxt;
         interval     <= interval_nxt;
         interval_ovf <= interval_ovf_nxt;
      end
   end

   // The interval covers blank and error accepts; only a decoded digit restarts it.
   always_comb begin
      state_nxt        = state;
      icnt_nxt         = icnt;
      ovf_nxt          = ovf_int;
      interval_nxt     = interval;
      interval_ovf_nxt = interval_ovf;
      if (ena) begin
         case (state)
            WAIT_FIRST: begin
               if (take_hit) begin
                  state_nxt = RUN;
                  icnt_nxt  = ICNT_ONE;
               end
            end
            RUN: begin
               if (icnt == ICNT_MAX) ovf_nxt = 1'b1;
               else                  icnt_nxt = icnt + 1'b1;
               if (take_hit) begin
                  interval_nxt     = icnt;
                  interval_ovf_nxt = ovf_int;
                  icnt_nxt         = ICNT_ONE;
                  ovf_nxt          = 1'b0;
               end
            end
            default: state_nxt = WAIT_FIRST;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - bench for seg7_reader: run-length model of the filter plus literal timing pins
module tb_seg7_reader;

   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [6:0]  seg_in;

   logic [3:0]  digit0, digit1;
   logic        dv0, dv1, blank0, blank1, err0, err1, ovf0, ovf1;
   logic [23:0] iv0;
   logic [3:0]  iv1;

   seg7_reader #(.STABLE_CYCLES(SC), .CNT_W(24)) dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in),
      .digit(digit0), .digit_valid(dv0), .blank(blank0), .seg_err(err0),
      .interval(iv0), .interval_ovf(ovf0));

   seg7_reader #(.STABLE_CYCLES(SC), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in),
      .digit(digit1), .digit_valid(dv1), .blank(blank1), .seg_err(err1),
      .interval(iv1), .interval_ovf(ovf1));

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int err_cnt = 0;

   typedef struct {
      int          cyc;
      logic [3:0]  d;
      logic [23:0] i0;
      logic        o0;
      logic [3:0]  i1;
      logic        o1;
   } rec_t;
   rec_t pulses[$];

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Model: a pattern is taken once it has been seen on the synced bus for more than SC
   // enabled cycles and differs from the last taken pattern; results appear one enabled
   // cycle later. The interval is the true count of enabled cycles, saturated per width.
   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [6:0] m_q1, m_sync, run_val, m_acc, m_pat;
   int         run_len;
   bit         m_pend, m_started, m_haveT, m_blank, m_dv, m_err;
   longint     m_cnt, m_T;
   logic [3:0] m_digit;

   function automatic int lookup(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
      return -1;
   endfunction

   function automatic longint exp_iv(input longint maxv);
      if (!m_haveT) return 0;
      return (m_T > maxv) ? maxv : m_T;
   endfunction

   task automatic model_reset();
      m_q1 = 0; m_sync = 0; run_val = 0; run_len = 1; m_acc = 0; m_pat = 0;
      m_pend = 0; m_started = 0; m_haveT = 0; m_blank = 0; m_dv = 0; m_err = 0;
      m_cnt = 0; m_T = 0; m_digit = 0;
   endtask

   task automatic model_step();
      logic [6:0] s;
      bit         acc;
      int         idx;
      s      = m_sync;
      m_sync = m_q1;
      m_q1   = seg_in;
      m_dv   = 0;
      m_err  = 0;
      if (ena) begin
         if (m_started) m_cnt++;
         if (m_pend) begin
            idx = lookup(m_pat);
            if (idx >= 0) begin
               m_digit = idx[3:0];
               m_dv    = 1;
               m_blank = 0;
               if (m_started) begin m_T = m_cnt; m_haveT = 1; end
               m_started = 1;
               m_cnt     = 0;
            end else if (m_pat == 7'h00) begin
               m_blank = 1;
            end else begin
               m_err = 1;
            end
         end
         acc = (s == run_val) && (run_len >= SC) && (s != m_acc);
         if (s == run_val) run_len++;
         else begin run_val = s; run_len = 1; end
         m_pend = acc;
         if (acc) begin m_acc = s; m_pat = s; end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      check("dv0",     dv0,    m_dv & ena);
      check("dv1",     dv1,    m_dv & ena);
      check("err0",    err0,   m_err & ena);
      check("err1",    err1,   m_err & ena);
      check("digit0",  digit0, m_digit);
      check("digit1",  digit1, m_digit);
      check("blank0",  blank0, m_blank);
      check("blank1",  blank1, m_blank);
      check("iv0",     iv0,    exp_iv(64'd16777215));
      check("ovf0",    ovf0,   m_haveT && m_T > 16777215);
      check("iv1",     iv1,    exp_iv(64'd15));
      check("ovf1",    ovf1,   m_haveT && m_T > 15);
      if (dv0) pulses.push_back('{cyc, digit0, iv0, ovf0, iv1, ovf1});
      if (err0) err_cnt++;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int d_exp  [7] = '{0, 1, 2, 3, 4, 5, 6};
   int i0_exp [7] = '{0, 20, 62, 15, 16, 5, 40};
   int i1_exp [7] = '{0, 15, 15, 15, 15, 5, 15};
   int o1_exp [7] = '{0, 1, 1, 0, 1, 0, 1};
   int c0, e;

   initial begin
      rst_n = 1'b0; ena = 1'b1; seg_in = 7'h7F;
      wait_cycles(5);
      check("rst_digit", digit0, 0);
      check("rst_blank", blank0, 0);
      check("rst_iv",    iv0, 0);
      check("rst_ovf1",  ovf1, 0);
      check("rst_dv",    dv0, 0);
      check("rst_err",   err0, 0);

      rst_n = 1'b1; seg_in = 7'h00;
      wait_cycles(12);
      check("idle_pulses", pulses.size(), 0);
      check("idle_err",    err_cnt, 0);

      c0 = cyc; seg_in = 7'h3F; wait_cycles(20);
      seg_in = 7'h06; wait_cycles(15);
      // change after edge c0 settles before edge c0+1; outputs land 7 edges after that
      if (pulses.size() > 0) check("first_latency", pulses[0].cyc - c0, 8);
      else                   check("first_latency_missing", 0, 1);

      seg_in = 7'h4F; wait_cycles(2);
      seg_in = 7'h06; wait_cycles(15);
      check("glitch_pulses", pulses.size(), 2);
      check("glitch_digit",  digit0, 1);

      seg_in = 7'h01; wait_cycles(15);
      check("bad_err_cnt", err_cnt, 1);
      check("bad_digit",   digit0, 1);
      seg_in = 7'h00; wait_cycles(15);
      check("blank_set",   blank0, 1);
      seg_in = 7'h5B; wait_cycles(15);
      check("blank_clr",   blank0, 0);

      seg_in = 7'h4F; wait_cycles(16);
      seg_in = 7'h66; wait_cycles(5);
      seg_in = 7'h6D; wait_cycles(40);
      seg_in = 7'h7D; wait_cycles(15);

      check("pulse_cnt", pulses.size(), 7);
      for (int i = 0; i < 7 && i < pulses.size(); i++) begin
         check($sformatf("p%0d_digit", i), pulses[i].d,  d_exp[i]);
         check($sformatf("p%0d_iv0", i),   pulses[i].i0, i0_exp[i]);
         check($sformatf("p%0d_ovf0", i),  pulses[i].o0, 0);
         check($sformatf("p%0d_iv1", i),   pulses[i].i1, i1_exp[i]);
         check($sformatf("p%0d_ovf1", i),  pulses[i].o1, o1_exp[i]);
      end

      seg_in = 7'h07; wait_cycles(3);
      #3 rst_n = 1'b0;
      #1;
      check("async_digit", digit0, 0);
      check("async_iv0",   iv0, 0);
      check("async_iv1",   iv1, 0);
      check("async_ovf1",  ovf1, 0);
      wait_cycles(2);
      rst_n = 1'b1;
      pulses.delete();
      wait_cycles(15);
      if (pulses.size() > 0) begin
         check("post_rst_digit", pulses[0].d, 7);
         check("post_rst_iv0",   pulses[0].i0, 0);
      end else check("post_rst_missing", 0, 1);

      ena = 1'b0; seg_in = 7'h7F; wait_cycles(12);
      check("ena_off_pulses", pulses.size(), 1);
      e = cyc; ena = 1'b1; wait_cycles(12);
      check("ena_on_pulses", pulses.size(), 2);
      if (pulses.size() > 1) begin
         check("ena_latency", pulses[1].cyc - e, 6);
         check("ena_digit",   pulses[1].d, 8);
         check("ena_iv0",     pulses[1].i0, 13);
         check("ena_iv1",     pulses[1].i1, 13);
      end else check("ena_pulse_missing", 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
